// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: registered Tnew shadow of the in-flight writers after D.
// Produces the D-stage stall, per-operand forward selects and the mult/div
// busy interlock. Entry k of the scoreboard mirrors post-D stage k
// (0 = E, 1 = M, 2 = W, ...), and each entry's Tnew counts down as it ages.
module hazard_scoreboard #(
  parameter  int NSTAGE   = 3,
  parameter  int TW       = 2,
  parameter  int MULT_CYC = 5,
  parameter  int DIV_CYC  = 10,
  localparam int FW       = $clog2(NSTAGE + 1),
  localparam int MD_MAX   = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC,
  localparam int MW       = $clog2(MD_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [4:0]    d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic [1:0]    d_md_start,
  input  logic          d_use_hilo,
  output logic          stall,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic          md_busy
);

  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // Tnew ages by one per cycle and never goes below "ready now".
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // The mult/div busy counter drains to zero and stays there.
  function automatic logic [MW-1:0] md_dec(input logic [MW-1:0] c);
    return (c == '0) ? '0 : c - MW'(1);
  endfunction

  // Scoreboard entries, one per tracked post-D stage.
  logic          sb_we   [NSTAGE];
  logic [4:0]    sb_a3   [NSTAGE];
  logic [TW-1:0] sb_tnew [NSTAGE];

  logic [MW-1:0] md_cnt;

  logic [NSTAGE-1:0] hit_rs;
  logic [NSTAGE-1:0] hit_rt;
  logic [NSTAGE-1:0] late_rs;
  logic [NSTAGE-1:0] late_rt;
  logic              data_stall;
  logic              hilo_stall;
  logic              issue;

  // ---- D stage: operand match against registered scoreboard ----

  // Per-entry match ($0 is never a real dependency) and "not ready in time".
  always_comb begin
    hit_rs  = '0;
    hit_rt  = '0;
    late_rs = '0;
    late_rt = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      hit_rs[k]  = sb_we[k] && (sb_a3[k] == d_rs) && (d_rs != 5'd0);
      hit_rt[k]  = sb_we[k] && (sb_a3[k] == d_rt) && (d_rt != 5'd0);
      late_rs[k] = sb_tnew[k] > d_tuse_rs;
      late_rt[k] = sb_tnew[k] > d_tuse_rt;
    end
  end

  // Any matching writer that cannot deliver by Tuse stalls, not just the youngest.
  assign data_stall = (d_use_rs && |(hit_rs & late_rs)) ||
                      (d_use_rt && |(hit_rt & late_rt));

  // mf/mt hi/lo or a new mult/div waits until the unit drains; no restart.
  assign hilo_stall = d_use_hilo && md_busy;

  assign stall   = d_valid && (data_stall || hilo_stall);
  assign issue   = d_valid && !stall;
  assign md_busy = (md_cnt != '0);

  // Youngest matching writer decides the rs source; walking oldest to
  // youngest lets the youngest hit win, so a pending younger writer hides
  // an older ready one and selects the register file.
  always_comb begin
    fwd_rs = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (hit_rs[k]) begin
        fwd_rs = (sb_tnew[k] == '0) ? FW'(k + 1) : '0;
      end
    end
  end

  // Same youngest-wins selection for rt.
  always_comb begin
    fwd_rt = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (hit_rt[k]) begin
        fwd_rt = (sb_tnew[k] == '0) ? FW'(k + 1) : '0;
      end
    end
  end

  // ---- D -> E boundary and E.. shadow shift ----

  // Issue (or a bubble on stall / empty D) enters entry 0; older entries age
  // one stage with Tnew counting down, and the oldest falls off the end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        sb_we[k]   <= 1'b0;
        sb_a3[k]   <= '0;
        sb_tnew[k] <= '0;
      end
    end else begin
      sb_we[0]   <= issue && d_we;
      sb_a3[0]   <= issue ? d_a3   : '0;
      sb_tnew[0] <= issue ? d_tnew : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        sb_we[k]   <= sb_we[k-1];
        sb_a3[k]   <= sb_a3[k-1];
        sb_tnew[k] <= tnew_dec(sb_tnew[k-1]);
      end
    end
  end

  // ---- mult/div busy counter ----

  // Loaded only when the starting instruction actually leaves D.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (issue && (d_md_start == MD_MULT)) begin
      md_cnt <= MW'(MULT_CYC);
    end else if (issue && (d_md_start == MD_DIV)) begin
      md_cnt <= MW'(DIV_CYC);
    end else begin
      md_cnt <= md_dec(md_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: an age-based history model checked every
// cycle, plus directed instruction pairs with hand-derived stall counts and
// forward selects.
module tb_hazard_scoreboard;

  localparam int NSTAGE   = 3;
  localparam int TW       = 2;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int HN       = 8192;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          d_valid;
  logic [4:0]    d_rs, d_rt, d_a3;
  logic          d_use_rs, d_use_rt, d_we, d_use_hilo;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic [1:0]    d_md_start;
  logic          stall, md_busy;
  logic [1:0]    fwd_rs, fwd_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSTAGE(NSTAGE), .TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_a3(d_a3),
    .d_tnew(d_tnew), .d_md_start(d_md_start), .d_use_hilo(d_use_hilo),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: history of what entered E each cycle ----------
  logic     h_we [HN];
  logic [4:0] h_a3 [HN];
  int       h_tn [HN];
  int       cyc = 0;
  int       base = 0;
  int       md_n0 = 0;
  int       md_len = 0;
  logic     m_issue = 1'b0;

  // Writer that entered E k cycles ago now sits in stage k with Tnew reduced by its age.
  function automatic void op_model(input logic [4:0] r, input int tuse,
                                   output bit st, output int fw);
    bit found;
    int idx, tn;
    found = 0; st = 0; fw = 0;
    for (int k = 0; k < NSTAGE; k++) begin
      idx = cyc - k;
      if (idx > base && h_we[idx] && h_a3[idx] == r && r != 5'd0) begin
        tn = h_tn[idx] - k;
        if (tn < 0) tn = 0;
        if (tn > tuse) st = 1;
        if (!found) begin
          found = 1;
          fw = (tn == 0) ? k + 1 : 0;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    bit srs, srt, busy, st;
    int frs, frt, rem;
    op_model(d_rs, int'(d_tuse_rs), srs, frs);
    op_model(d_rt, int'(d_tuse_rt), srt, frt);
    rem  = md_len - (cyc - md_n0);
    busy = rem > 0;
    st   = d_valid && ((d_use_rs && srs) || (d_use_rt && srt) || (d_use_hilo && busy));
    m_issue = d_valid && !st;
    chk("cycle stall",   int'(stall),   int'(st));
    chk("cycle fwd_rs",  int'(fwd_rs),  frs);
    chk("cycle fwd_rt",  int'(fwd_rt),  frt);
    chk("cycle md_busy", int'(md_busy), int'(busy));
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base   <= cyc;
      md_len <= 0;
    end else begin
      cyc <= cyc + 1;
      h_we[cyc+1] <= m_issue && d_we;
      h_a3[cyc+1] <= d_a3;
      h_tn[cyc+1] <= int'(d_tnew);
      if (m_issue && d_md_start == 2'b01) begin
        md_n0 <= cyc + 1; md_len <= MULT_CYC;
      end else if (m_issue && d_md_start == 2'b10) begin
        md_n0 <= cyc + 1; md_len <= DIV_CYC;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
    d_tuse_rs = 2'd0; d_tuse_rt = 2'd0; d_we = 1'b0; d_a3 = 5'd0; d_tnew = 2'd0;
    d_md_start = 2'd0; d_use_hilo = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold an instruction in D until it issues; report stall cycles and the
  // forward selects seen in its issuing cycle.
  task automatic send(input logic [4:0] rs, rt, input logic urs, urt,
                      input logic [1:0] trs, trt, input logic we,
                      input logic [4:0] a3, input logic [1:0] tn, md,
                      input logic hilo, output int nst, output int frs, output int frt);
    bit done = 0;
    d_valid = 1'b1; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
    d_tuse_rs = trs; d_tuse_rt = trt; d_we = we; d_a3 = a3; d_tnew = tn;
    d_md_start = md; d_use_hilo = hilo;
    nst = 0; frs = 0; frt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin done = 1; break; end
      nst++;
      @(posedge clk); #1;
    end
    if (!done) chk("issue timeout", 0, 1);
    frs = int'(fwd_rs); frt = int'(fwd_rt);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic i_alu(input logic [4:0] rd, rs, rt, output int n, f1, f2);
    send(rs, rt, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, rd, 2'd1, 2'd0, 1'b0, n, f1, f2);
  endtask
  task automatic i_ori(input logic [4:0] rt, rs, output int n, f1, f2);
    send(rs, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, rt, 2'd1, 2'd0, 1'b0, n, f1, f2);
  endtask
  task automatic i_lw(input logic [4:0] rt, rs, output int n, f1, f2);
    send(rs, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, rt, 2'd2, 2'd0, 1'b0, n, f1, f2);
  endtask
  task automatic i_sw(input logic [4:0] rt, rs, output int n, f1, f2);
    send(rs, rt, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0, n, f1, f2);
  endtask
  task automatic i_beq(input logic [4:0] rs, rt, output int n, f1, f2);
    send(rs, rt, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0, n, f1, f2);
  endtask
  task automatic i_md(input logic [4:0] rs, rt, input logic [1:0] md, output int n, f1, f2);
    send(rs, rt, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0, md, 1'b1, n, f1, f2);
  endtask
  task automatic i_mf(input logic [4:0] rd, output int n, f1, f2);
    send(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, rd, 2'd1, 2'd0, 1'b1, n, f1, f2);
  endtask

  task automatic x3(input string nm, input int n, f1, f2, en, ef1, ef2);
    chk({nm, " stall cycles"}, n, en);
    chk({nm, " fwd_rs"}, f1, ef1);
    chk({nm, " fwd_rt"}, f2, ef2);
  endtask

  int n, f1, f2;

  initial begin
    idle();
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("reset stall", int'(stall), 0);
    chk("reset fwd_rs", int'(fwd_rs), 0);
    chk("reset fwd_rt", int'(fwd_rt), 0);
    chk("reset md_busy", int'(md_busy), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // ALU -> ALU: producer still in E is pending, one stage older is ready in M
    i_alu(5'd3, 5'd1, 5'd2, n, f1, f2); x3("addu3", n, f1, f2, 0, 0, 0);
    i_alu(5'd4, 5'd3, 5'd3, n, f1, f2); x3("subu4", n, f1, f2, 0, 0, 0);
    i_alu(5'd5, 5'd4, 5'd3, n, f1, f2); x3("addu5", n, f1, f2, 0, 0, 2);
    drain(4);

    // load-use: one bubble, then a branch on the ALU result
    i_lw(5'd5, 5'd0, n, f1, f2);        x3("lw5", n, f1, f2, 0, 0, 0);
    i_alu(5'd6, 5'd5, 5'd0, n, f1, f2); x3("addu6", n, f1, f2, 1, 0, 0);
    i_beq(5'd6, 5'd5, n, f1, f2);       x3("beq65", n, f1, f2, 1, 2, 0);
    drain(4);

    // load -> branch (tuse 0): two stalls, then forward from W
    i_lw(5'd7, 5'd0, n, f1, f2);  x3("lw7", n, f1, f2, 0, 0, 0);
    i_beq(5'd7, 5'd7, n, f1, f2); x3("beq77", n, f1, f2, 2, 3, 3);
    drain(4);

    // younger pending writer hides an older ready one
    i_alu(5'd8, 5'd0, 5'd0, n, f1, f2); x3("addu8", n, f1, f2, 0, 0, 0);
    i_lw(5'd8, 5'd0, n, f1, f2);        x3("lw8", n, f1, f2, 0, 0, 0);
    i_sw(5'd8, 5'd0, n, f1, f2);        x3("sw8", n, f1, f2, 0, 0, 0);
    i_beq(5'd8, 5'd0, n, f1, f2);       x3("beq80", n, f1, f2, 1, 3, 0);
    drain(4);

    // register $0 never stalls or forwards
    i_ori(5'd0, 5'd0, n, f1, f2);       x3("ori0", n, f1, f2, 0, 0, 0);
    i_alu(5'd1, 5'd0, 5'd0, n, f1, f2); x3("addu1", n, f1, f2, 0, 0, 0);
    i_lw(5'd0, 5'd0, n, f1, f2);        x3("lw0", n, f1, f2, 0, 0, 0);
    i_beq(5'd0, 5'd0, n, f1, f2);       x3("beq00", n, f1, f2, 0, 0, 0);
    drain(4);

    // mult/div interlock
    i_md(5'd20, 5'd21, 2'b01, n, f1, f2); x3("mult", n, f1, f2, 0, 0, 0);
    i_mf(5'd22, n, f1, f2);               x3("mfhi", n, f1, f2, 5, 0, 0);
    drain(2);
    i_md(5'd20, 5'd21, 2'b10, n, f1, f2); x3("div", n, f1, f2, 0, 0, 0);
    i_mf(5'd23, n, f1, f2);               x3("mflo", n, f1, f2, 10, 0, 0);
    drain(2);
    i_md(5'd20, 5'd21, 2'b01, n, f1, f2); x3("mult2", n, f1, f2, 0, 0, 0);
    i_md(5'd20, 5'd21, 2'b10, n, f1, f2); x3("div busy", n, f1, f2, 5, 0, 0);
    i_mf(5'd24, n, f1, f2);               x3("mflo2", n, f1, f2, 10, 0, 0);
    drain(12);

    // reset while a load is in E and the divider is busy
    i_md(5'd20, 5'd21, 2'b10, n, f1, f2); x3("div3", n, f1, f2, 0, 0, 0);
    i_lw(5'd11, 5'd0, n, f1, f2);         x3("lw11", n, f1, f2, 0, 0, 0);
    d_valid = 1'b1; d_rs = 5'd11; d_use_rs = 1'b1; d_tuse_rs = 2'd1;
    d_use_hilo = 1'b1; d_we = 1'b1; d_a3 = 5'd12; d_tnew = 2'd1;
    #1;
    chk("pre-reset stall", int'(stall), 1);
    chk("pre-reset md_busy", int'(md_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("async reset stall", int'(stall), 0);
    chk("async reset fwd_rs", int'(fwd_rs), 0);
    chk("async reset fwd_rt", int'(fwd_rt), 0);
    chk("async reset md_busy", int'(md_busy), 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    send(5'd11, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 5'd12, 2'd1, 2'd0, 1'b1, n, f1, f2);
    x3("after reset", n, f1, f2, 0, 0, 0);
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
